// File: rtl/hid_gamepad_pkg.sv
// rtl/hid_gamepad_pkg.sv - shared constants and repeat FSM encoding for the gamepad decoder
package hid_gamepad_pkg;

    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_B0    = 4;

    localparam logic [7:0] DEF_LO_ON  = 8'h40;
    localparam logic [7:0] DEF_LO_OFF = 8'h50;
    localparam logic [7:0] DEF_HI_ON  = 8'hC0;
    localparam logic [7:0] DEF_HI_OFF = 8'hB0;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

endpackage

// File: rtl/hid_gamepad_decoder_axis.sv
// rtl/hid_gamepad_decoder_axis.sv - hid_axis_hyst: one axis byte to low/high direction flags with hysteresis
module hid_axis_hyst
    import hid_gamepad_pkg::*;
#(
    parameter logic [7:0] C_lo_on  = DEF_LO_ON,
    parameter logic [7:0] C_lo_off = DEF_LO_OFF,
    parameter logic [7:0] C_hi_on  = DEF_HI_ON,
    parameter logic [7:0] C_hi_off = DEF_HI_OFF
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic       clear,
    input  logic [7:0] axis,
    output logic       lo,
    output logic       hi,
    output logic       lo_nxt,
    output logic       hi_nxt
);

    logic lo_set;
    logic hi_set;

    // Low direction wins if a misconfigured threshold pair lets both set conditions hold.
    always_comb begin
        lo_set = (axis < C_lo_on);
        hi_set = (axis > C_hi_on) && !lo_set;
        lo_nxt = lo;
        hi_nxt = hi;
        if (clear) begin
            lo_nxt = 1'b0;
            hi_nxt = 1'b0;
        end else if (valid) begin
            if (lo_set)
                lo_nxt = 1'b1;
            else if (axis > C_lo_off)
                lo_nxt = 1'b0;
            if (hi_set)
                hi_nxt = 1'b1;
            else if ((axis < C_hi_off) || lo_set)
                hi_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo <= 1'b0;
            hi <= 1'b0;
        end else begin
            lo <= lo_nxt;
            hi <= hi_nxt;
        end
    end

endmodule

// File: rtl/hid_gamepad_decoder.sv
// rtl/hid_gamepad_decoder.sv - gamepad report to button state, edge/repeat strobes, watchdog and counter
module hid_gamepad_decoder
    import hid_gamepad_pkg::*;
#(
    parameter int          C_report_bytes = 8,
    parameter int          C_x_byte       = 0,
    parameter int          C_y_byte       = 1,
    parameter int          C_btn_byte     = 5,
    parameter logic [7:0]  C_lo_on        = DEF_LO_ON,
    parameter logic [7:0]  C_lo_off       = DEF_LO_OFF,
    parameter logic [7:0]  C_hi_on        = DEF_HI_ON,
    parameter logic [7:0]  C_hi_off       = DEF_HI_OFF,
    parameter logic [23:0] C_repeat_delay = 24'd3000000,
    parameter logic [23:0] C_repeat_rate  = 24'd600000,
    parameter logic [23:0] C_timeout      = 24'd6000000
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [C_report_bytes*8-1:0] hid_report,
    input  logic                        hid_valid,
    output logic [11:0]                 btn_state,
    output logic [11:0]                 btn_press,
    output logic [11:0]                 btn_release,
    output logic [11:0]                 btn_repeat,
    output logic                        connected,
    output logic [15:0]                 report_cnt
);

    logic        x_lo, x_hi, y_lo, y_hi;
    logic        x_lo_nxt, x_hi_nxt, y_lo_nxt, y_hi_nxt;
    logic [7:0]  btn_byte_q;
    logic [23:0] wd_cnt;
    logic        tmo;
    logic        upd;
    logic [11:0] state_nxt;
    logic        press_any;
    logic [11:0] repeat_nxt;
    rpt_state_t  rpt_state, rpt_state_nxt;
    logic [23:0] rpt_timer, rpt_timer_nxt;
    logic        unused_report;

    assign unused_report = ^hid_report;

    hid_axis_hyst #(
        .C_lo_on(C_lo_on), .C_lo_off(C_lo_off), .C_hi_on(C_hi_on), .C_hi_off(C_hi_off)
    ) u_axis_x (
        .clk(clk), .rst(rst), .valid(hid_valid), .clear(tmo),
        .axis(hid_report[8*C_x_byte +: 8]),
        .lo(x_lo), .hi(x_hi), .lo_nxt(x_lo_nxt), .hi_nxt(x_hi_nxt)
    );

    hid_axis_hyst #(
        .C_lo_on(C_lo_on), .C_lo_off(C_lo_off), .C_hi_on(C_hi_on), .C_hi_off(C_hi_off)
    ) u_axis_y (
        .clk(clk), .rst(rst), .valid(hid_valid), .clear(tmo),
        .axis(hid_report[8*C_y_byte +: 8]),
        .lo(y_lo), .hi(y_hi), .lo_nxt(y_lo_nxt), .hi_nxt(y_hi_nxt)
    );

    // Timeout fires in the C_timeout-th consecutive cycle without a report; a report then wins.
    assign tmo = !hid_valid && connected && (wd_cnt == C_timeout - 24'd1);
    assign upd = hid_valid || tmo;

    always_comb begin
        btn_state                = '0;
        btn_state[BTN_RIGHT]     = x_hi;
        btn_state[BTN_LEFT]      = x_lo;
        btn_state[BTN_DOWN]      = y_hi;
        btn_state[BTN_UP]        = y_lo;
        btn_state[BTN_B0 +: 8]   = btn_byte_q;
    end

    always_comb begin
        state_nxt = btn_state;
        if (hid_valid) begin
            state_nxt[BTN_RIGHT]   = x_hi_nxt;
            state_nxt[BTN_LEFT]    = x_lo_nxt;
            state_nxt[BTN_DOWN]    = y_hi_nxt;
            state_nxt[BTN_UP]      = y_lo_nxt;
            state_nxt[BTN_B0 +: 8] = hid_report[8*C_btn_byte +: 8];
        end else if (tmo) begin
            state_nxt = '0;
        end
    end

    assign press_any = upd && (|(state_nxt & ~btn_state));

    always_comb begin
        rpt_state_nxt = rpt_state;
        rpt_timer_nxt = rpt_timer + 24'd1;
        repeat_nxt    = '0;
        if (state_nxt == '0) begin
            rpt_state_nxt = RPT_IDLE;
            rpt_timer_nxt = '0;
        end else if (press_any) begin
            rpt_state_nxt = RPT_DELAY;
            rpt_timer_nxt = '0;
        end else begin
            case (rpt_state)
                RPT_IDLE: rpt_timer_nxt = '0;
                RPT_DELAY: begin
                    if (rpt_timer == C_repeat_delay - 24'd1) begin
                        rpt_state_nxt = RPT_REPEAT;
                        rpt_timer_nxt = '0;
                        repeat_nxt    = state_nxt;
                    end
                end
                RPT_REPEAT: begin
                    if (rpt_timer == C_repeat_rate - 24'd1) begin
                        rpt_timer_nxt = '0;
                        repeat_nxt    = state_nxt;
                    end
                end
                default: begin
                    rpt_state_nxt = RPT_IDLE;
                    rpt_timer_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_state <= RPT_IDLE;
            rpt_timer <= '0;
        end else begin
            rpt_state <= rpt_state_nxt;
            rpt_timer <= rpt_timer_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_byte_q  <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            btn_repeat  <= '0;
            connected   <= 1'b0;
            report_cnt  <= '0;
            wd_cnt      <= '0;
        end else begin
            btn_byte_q  <= state_nxt[BTN_B0 +: 8];
            btn_press   <= upd ? (state_nxt & ~btn_state) : '0;
            btn_release <= upd ? (~state_nxt & btn_state) : '0;
            btn_repeat  <= repeat_nxt;
            if (hid_valid) begin
                connected  <= 1'b1;
                report_cnt <= report_cnt + 16'd1;
            end else if (tmo) begin
                connected  <= 1'b0;
            end
            if (hid_valid)
                wd_cnt <= '0;
            else if (wd_cnt != C_timeout)
                wd_cnt <= wd_cnt + 24'd1;
        end
    end

endmodule

// File: doc/hid_gamepad_decoder.md
Name: hid_gamepad_decoder

Overview:
- Sits directly downstream of usbh_host_hid, in the clk_usb domain.
- Consumes the raw hid_report/hid_valid pair and turns an 8-byte generic gamepad report into a 12-bit registered button state.
- Generates press, release and auto-repeat strobes, a connected flag (watchdog) and a report counter.
- Feeds display/control logic in place of raw report bytes.

Parameters:
- C_report_bytes, 8, report width in bytes; must match the host instance.
- C_x_byte, 0, byte index of the X axis.
- C_y_byte, 1, byte index of the Y axis.
- C_btn_byte, 5, byte index of the 8 button bits.
- C_lo_on, 8'h40, axis value strictly below this asserts low direction.
- C_lo_off, 8'h50, axis value strictly above this deasserts low direction.
- C_hi_on, 8'hC0, axis value strictly above this asserts high direction.
- C_hi_off, 8'hB0, axis value strictly below this deasserts high direction.
- C_repeat_delay, 24'd3000000, cycles from last new press to first repeat.
- C_repeat_rate, 24'd600000, cycles between subsequent repeats.
- C_timeout, 24'd6000000, cycles without hid_valid before disconnect.

Ports:
- clk  in  1  USB clock (6 or 48 MHz).
- rst  in  1  asynchronous, active-high reset.
- hid_report  in  C_report_bytes*8  report; byte k = bits [8k+7:8k].
- hid_valid  in  1  one-cycle strobe; hid_report is stable in that cycle.
- btn_state  out  12  held inputs: [0] right, [1] left, [2] down, [3] up, [11:4] = button byte bits [7:0].
- btn_press  out  12  one-cycle 0→1 edge strobes.
- btn_release  out  12  one-cycle 1→0 edge strobes.
- btn_repeat  out  12  one-cycle auto-repeat strobe; equals btn_state on a repeat tick.
- connected  out  1  a report was received within the last C_timeout cycles.
- report_cnt  out  16  count of hid_valid strobes; wraps 16'hFFFF→0.

Behaviour:
- Reset: all outputs 0, repeat FSM in IDLE, watchdog counter 0.
- Latency:
  - hid_valid in cycle N → btn_state, btn_press, btn_release and report_cnt update at the edge ending cycle N, visible in N+1.
  - connected goes 1 at the same time.
- Axis hysteresis, per direction flag:
  - Set when the on-condition holds at a hid_valid.
  - Clear when the off-condition holds.
  - Otherwise hold its value.
  - Low and high flags of one axis are mutually exclusive by the thresholds; if both set conditions are met (only possible with bad parameters), low wins.
- Buttons: btn_state[11:4] is taken directly from hid_report byte C_btn_byte at each hid_valid.
- Edges: btn_press = new & ~old, btn_release = ~new & old, evaluated only on an update (hid_valid or timeout). Both are 0 in every other cycle.
- Watchdog:
  - Counter increments every cycle and saturates at C_timeout; hid_valid clears it to 0.
  - When it reaches C_timeout while connected=1:
    - connected←0.
    - btn_state←0.
    - btn_release←old btn_state for one cycle.
    - Repeat FSM→IDLE.
  - hid_valid in the same cycle as the timeout wins: no disconnect, normal update.
- Repeat FSM, with one shared 24-bit timer:
  - IDLE: any press strobe → DELAY, timer←0.
  - DELAY: timer reaches C_repeat_delay-1 → REPEAT, timer←0, btn_repeat←btn_state.
  - REPEAT: timer reaches C_repeat_rate-1 → timer←0, btn_repeat←btn_state.
  - From DELAY or REPEAT:
    - Any new press → DELAY, timer←0, no repeat strobe that cycle.
    - btn_state becomes 0 → IDLE, no strobe.
  - Release of some, but not all, held bits leaves the state unchanged.
- report_cnt increments on every hid_valid, including identical reports.
- Reports with no bit changes produce no strobes.
- rst asserted mid-operation clears everything immediately (asynchronous); no strobes on reset release.

Decomposition:
- Package hid_gamepad_pkg:
  - Bit index constants (BTN_RIGHT=0, BTN_LEFT=1, BTN_DOWN=2, BTN_UP=3, BTN_B0=4).
  - Repeat FSM state encoding (IDLE, DELAY, REPEAT).
  - Default threshold constants.
- Sub-module hid_axis_hyst:
  - Inputs: clk, rst, valid, 8-bit axis value.
  - Outputs: registered lo/hi flags.
  - Instantiated twice (X→left/right, Y→up/down).

Test Plan (use C_repeat_delay=10, C_repeat_rate=4, C_timeout=50):
- Reset then idle 20 cycles → all outputs 0; connected=0; report_cnt=0.
- Report X=7F, Y=7F, btn=00, then btn=05 → btn_state=12'h050; btn_press=12'h050 for exactly 1 cycle; report_cnt=2; connected=1.
- Hysteresis: X sequence 30, 48, 52, 80 (one hid_valid each) → left=1, 1, 0, 0; X sequence C8, B8, AF → right=1, 1, 0.
- Hold btn=01 with reports every 3 cycles → first btn_repeat=12'h010 10 cycles after the press strobe, then every 4 cycles; adding btn=03 restarts the delay; btn=00 → release strobe, no further repeats.
- Hold btn=80 and stop reports → 50 cycles after the last hid_valid: connected=0, btn_state=0, btn_release=12'h800 for 1 cycle; hid_valid exactly on the timeout cycle → connected stays 1.
- Send 65537 reports → report_cnt=1 (wrap).
- Assert rst during REPEAT → outputs 0 immediately, no strobe after release.
